cpu_sram_bridge: RTL and testbench
==================================

# cpu_sram_bridge

Sits directly downstream of the CPU core's `inst_sram_*` and `data_sram_*` ports and converts them into one shared split-transaction bus. The bus uses a req/addr_ok/data_ok handshake. Data and instruction accesses from the same cycle are serialized, data first. The bridge raises `stallreq` to freeze the pipeline until both results are buffered, then releases the pipeline for exactly one cycle with the results presented.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both the CPU side and the bus side.
- `DATA_W`, 32, data width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `inst_sram_en`  in  1  CPU instruction fetch request.
- `inst_sram_addr`  in  ADDR_W  fetch address, word-aligned.
- `inst_sram_rdata`  out  DATA_W  buffered fetched instruction.
- `data_sram_en`  in  1  CPU data access request.
- `data_sram_wen`  in  4  byte write enables; `0000` means read.
- `data_sram_addr`  in  ADDR_W  data address, already masked by the core.
- `data_sram_wdata`  in  DATA_W  store data, already byte-lane aligned.
- `data_sram_rdata`  out  DATA_W  buffered load data.
- `stallreq`  out  1  pipeline freeze request to the ctrl stall logic.
- `req`  out  1  bus request valid.
- `wr`  out  1  bus write.
- `size`  out  2  access size: 0 byte, 1 halfword, 2 word.
- `addr`  out  ADDR_W  bus address.
- `wstrb`  out  4  bus byte strobes.
- `wdata`  out  DATA_W  bus write data.
- `addr_ok`  in  1  slave has accepted the request this cycle.
- `data_ok`  in  1  slave has returned data or a write response this cycle.
- `rdata`  in  DATA_W  bus read data, valid when `data_ok` is high.

## Operation
- FSM states: IDLE, DREQ, DWAIT, IREQ, IWAIT, DONE.
- IDLE transitions:
  - `data_sram_en` → DREQ.
  - else `inst_sram_en` → IREQ.
  - else stay in IDLE.
- DREQ:
  - `req`=1; `wr` = |`data_sram_wen`; `wstrb` = `data_sram_wen`; `addr`/`wdata` taken from the data port.
  - `addr_ok` → DWAIT.
- DWAIT:
  - `req`=0.
  - On `data_ok`: capture `rdata` into the data buffer (reads only; writes leave the buffer unchanged).
  - Then go to IREQ if `inst_sram_en`, else DONE.
- IREQ:
  - `req`=1, `wr`=0, `size`=2, `wstrb`=0, `addr`=`inst_sram_addr`.
  - `addr_ok` → IWAIT.
- IWAIT: on `data_ok`, capture `rdata` into the instruction buffer → DONE.
- DONE: unconditionally → IDLE next cycle.
- `size` decode from `wen`:
  - `0000`/`1111` → 2.
  - `0011`/`1100` → 1.
  - single-bit patterns → 0.
  - any other pattern → 2.
- `stallreq` (combinational) = (state≠DONE) && (`inst_sram_en` || `data_sram_en`).
- The CPU holds all request inputs stable while `stallreq`=1.
- `inst_sram_rdata`/`data_sram_rdata` are driven from registers. Each holds its last captured value until the next capture.
- `data_ok` or `addr_ok` arriving in any state other than the one expecting it is ignored.
- At most one transaction is outstanding; a new request is never issued before the previous `data_ok`.

## Timing
- Reset values: all outputs 0, both buffers 0, state IDLE. Reset takes effect mid-transaction and abandons it; the slave is reset by the same `rstn`.
- With a zero-wait slave (`addr_ok` in the request cycle, `data_ok` the following cycle):
  - Data-only access: request seen in cycle 0 → DONE in cycle 3, `stallreq` high in cycles 0–2.
  - Fetch-only access: same timing.
  - Fetch plus data: DONE in cycle 5.
- Each slave wait state adds one cycle.
- `stallreq` is low in DONE, so the pipeline advances on the DONE→IDLE edge. New requests are sampled in the following IDLE cycle.
- `req`, `wr`, `size`, `addr`, `wstrb`, `wdata` stay constant from the first `req` cycle until `addr_ok`.

## Structure
- Shared package `bridge_pkg`:
  - state enum (3-bit encoding);
  - `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD` constants;
  - `BRIDGE_IDLE` reset constants.
- One sub-module, `wen_to_size`: combinational decode from 4-bit enables to 2-bit size.
- Everything else, including the FSM, bus mux and buffers, lives in `cpu_sram_bridge`.

## Test plan
- Load only: `data_sram_en`=1, `wen`=0, addr 0x0000_1000; slave returns 0xDEADBEEF with 0 waits.
  → `req`/`wr`=0/`size`=2 in cycle 1; `data_sram_rdata`=0xDEADBEEF in DONE (cycle 3); `stallreq` high for exactly cycles 0–2.
- Byte store: `wen`=`0100`, wdata 0x00AB_0000, plus a simultaneous fetch at 0xBFC0_0000 returning 0x2408_0001.
  → data transaction first with `wr`=1/`size`=0/`wstrb`=`0100`, then the fetch; `inst_sram_rdata`=0x2408_0001 at DONE (cycle 5); data buffer unchanged.
- Slave backpressure: `addr_ok` held low for 3 cycles, `data_ok` delayed by 2 cycles.
  → bus outputs stable throughout; DONE reached 5 cycles later than the zero-wait case.
- Halfword size decode: `wen`=`1100` → `size`=1; `wen`=`0011` → `size`=1.
- Reset during IWAIT: `rstn` low → state IDLE, `req`=0, `stallreq`=0, both buffers 0, immediately and without a clock edge.
- Spurious `data_ok` in IDLE and in DREQ → no state change and no buffer update.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-bus SRAM bridge: FSM encoding, bus
// size codes and the values everything returns to on reset.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DREQ  = 3'd1,
    ST_DWAIT = 3'd2,
    ST_IREQ  = 3'd3,
    ST_IWAIT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Reset values: FSM parked in IDLE, read buffers cleared.
  localparam state_t      BRIDGE_IDLE_STATE = ST_IDLE;
  localparam logic [31:0] BRIDGE_IDLE_WORD  = 32'h0000_0000;

endpackage

// File: rtl/cpu_sram_bridge_wen_to_size.sv
// Decodes the CPU byte-enable pattern into a bus access size. Reads
// (0000), full words and irregular patterns all go out as word accesses.
module wen_to_size
  import bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size
);

  // Pure lookup of the enable pattern.
  always_comb begin
    size = SIZE_WORD;
    case (wen)
      4'b0000, 4'b1111:                   size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/cpu_sram_bridge.sv
// Bridges the core's inst_sram/data_sram ports onto one split-transaction
// bus (req/addr_ok/data_ok). A data access is issued before a fetch from
// the same cycle; the pipeline is stalled until both results are buffered,
// then released for the single DONE cycle.
//
// Bus handshake: the bridge holds req and every request field constant
// from the first req cycle until the slave raises addr_ok in a cycle where
// req is high; the request is accepted on that rising edge. The slave then
// returns exactly one data_ok (with rdata for reads). Only one transaction
// is ever outstanding, and addr_ok/data_ok seen in any state that is not
// waiting for them are ignored.
module cpu_sram_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_sram_en,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output state_t            fsm_state
);

  state_t      state, state_nxt;
  logic [1:0]  data_size;
  logic        cap_data;
  logic        cap_inst;

  wen_to_size u_wen_to_size (
    .wen  (data_sram_wen),
    .size (data_size)
  );

  assign fsm_state = state;

  // Freeze the pipeline whenever the core asks for anything, except in DONE
  // where the buffered results are handed over; held low during reset.
  assign stallreq = rstn && (state != ST_DONE) && (inst_sram_en || data_sram_en);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BRIDGE_IDLE_STATE;
    else       state <= state_nxt;
  end

  // Next-state logic, bus request mux and buffer capture strobes.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    wr        = 1'b0;
    size      = SIZE_BYTE;
    addr      = '0;
    wstrb     = 4'b0000;
    wdata     = '0;
    cap_data  = 1'b0;
    cap_inst  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_sram_en)      state_nxt = ST_DREQ;
        else if (inst_sram_en) state_nxt = ST_IREQ;
      end
      ST_DREQ: begin
        req   = 1'b1;
        wr    = |data_sram_wen;
        size  = data_size;
        addr  = data_sram_addr;
        wstrb = data_sram_wen;
        wdata = data_sram_wdata;
        if (addr_ok) state_nxt = ST_DWAIT;
      end
      ST_DWAIT: begin
        if (data_ok) begin
          // Write responses carry no data; only loads refresh the buffer.
          cap_data  = (data_sram_wen == 4'b0000);
          state_nxt = inst_sram_en ? ST_IREQ : ST_DONE;
        end
      end
      ST_IREQ: begin
        req  = 1'b1;
        size = SIZE_WORD;
        addr = inst_sram_addr;
        if (addr_ok) state_nxt = ST_IWAIT;
      end
      ST_IWAIT: begin
        if (data_ok) begin
          cap_inst  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = BRIDGE_IDLE_STATE;
    endcase
  end

  // Result buffers: each keeps its last captured word until the next capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_sram_rdata <= BRIDGE_IDLE_WORD;
      inst_sram_rdata <= BRIDGE_IDLE_WORD;
    end else begin
      if (cap_data) data_sram_rdata <= rdata;
      if (cap_inst) inst_sram_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Bench for cpu_sram_bridge: a behavioural bus slave with programmable
// wait states, a bus-request scoreboard, and one task per scenario.
module tb_cpu_sram_bridge;
  import bridge_pkg::*;

  localparam int TXN_W = 71; // {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}

  logic        clk;
  logic        rstn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  state_t      fsm_state;

  // slave-side drives and spurious-pulse injection
  logic        s_aok, s_dok, spur_dok;
  logic [31:0] s_rdata;
  int          addr_wait, data_wait;

  int          checks;
  int          failures;
  logic [TXN_W-1:0] exp_q[$];
  logic [31:0] cur_inst, cur_data;

  assign addr_ok = s_aok;
  assign data_ok = s_dok | spur_dok;
  assign rdata   = spur_dok ? 32'h1111_1111 : s_rdata;

  cpu_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .req             (req),
    .wr              (wr),
    .size            (size),
    .addr            (addr),
    .wstrb           (wstrb),
    .wdata           (wdata),
    .addr_ok         (addr_ok),
    .data_ok         (data_ok),
    .rdata           (rdata),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory contents.
  function automatic logic [31:0] resp_of(input logic [31:0] a);
    if (a == 32'h0000_1000)      resp_of = 32'hDEAD_BEEF;
    else if (a == 32'hBFC0_0000) resp_of = 32'h2408_0001;
    else                         resp_of = a ^ 32'hA5A5_A5A5;
  endfunction

  // ---------------- bus slave + scoreboard ----------------
  initial begin : slave
    logic             pending, in_req;
    int               acnt, dcnt;
    logic [31:0]      last_addr;
    logic [TXN_W-1:0] first_txn, got, exp;
    pending = 0; in_req = 0; acnt = 0; dcnt = 0; last_addr = '0;
    first_txn = '0;
    s_aok = 0; s_dok = 0; s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      s_aok = 0; s_dok = 0;
      if (!rstn) begin
        pending = 0; in_req = 0; acnt = addr_wait;
      end else if (pending) begin
        if (dcnt == 0) begin
          s_dok = 1; s_rdata = resp_of(last_addr); pending = 0;
        end else dcnt--;
      end else if (req) begin
        got = {wr, size, wstrb, addr, wdata};
        if (!in_req) begin
          in_req = 1; first_txn = got; acnt = addr_wait;
        end else begin
          checks++;
          if (got !== first_txn) begin
            failures++;
            $display("FAIL bus_stable got %h exp %h", got, first_txn);
          end
        end
        if (acnt == 0) begin
          s_aok = 1; in_req = 0; pending = 1; dcnt = data_wait; last_addr = addr;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bus_txn got %h exp none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              failures++;
              $display("FAIL bus_txn got %h exp %h", got, exp);
            end
          end
        end else acnt--;
      end else begin
        acnt = addr_wait;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    inst_sram_en = 0; data_sram_en = 0; data_sram_wen = 4'b0000;
  endtask

  // One CPU request, checked cycle by cycle against the expected DONE cycle.
  task automatic run_access(input string name, input logic ien, input logic [31:0] ia,
                            input logic den, input logic [3:0] wen, input logic [31:0] da,
                            input logic [31:0] wd, input logic [1:0] exp_size, input int exp_done);
    logic [31:0] exp_inst, exp_data;
    exp_inst = ien ? resp_of(ia) : cur_inst;
    exp_data = (den && wen == 4'b0000) ? resp_of(da) : cur_data;
    if (den) exp_q.push_back({(wen != 4'b0000), exp_size, wen, da, wd});
    if (ien) exp_q.push_back({1'b0, 2'd2, 4'b0000, ia, 32'h0});
    @(posedge clk); #2;
    inst_sram_en = ien; inst_sram_addr = ia;
    data_sram_en = den; data_sram_wen = wen; data_sram_addr = da; data_sram_wdata = wd;
    for (int cyc = 0; cyc <= exp_done; cyc++) begin
      @(negedge clk);
      checks++;
      if (stallreq !== (cyc < exp_done)) begin
        failures++;
        $display("FAIL %s stallreq cyc %0d got %b exp %b", name, cyc, stallreq, (cyc < exp_done));
      end
      if (cyc == 1) begin
        checks++;
        if (req !== 1'b1) begin
          failures++;
          $display("FAIL %s req_cyc1 got %b exp 1", name, req);
        end
      end
    end
    checks++;
    if (fsm_state !== ST_DONE) begin
      failures++;
      $display("FAIL %s done_state got %0d exp %0d", name, fsm_state, ST_DONE);
    end
    checks++;
    if (inst_sram_rdata !== exp_inst) begin
      failures++;
      $display("FAIL %s inst_buf got %h exp %h", name, inst_sram_rdata, exp_inst);
    end
    checks++;
    if (data_sram_rdata !== exp_data) begin
      failures++;
      $display("FAIL %s data_buf got %h exp %h", name, data_sram_rdata, exp_data);
    end
    cur_inst = exp_inst; cur_data = exp_data;
    @(posedge clk); #2;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_IDLE || stallreq !== 1'b0) begin
      failures++;
      $display("FAIL %s back_idle got state %0d stall %b exp 0 0", name, fsm_state, stallreq);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0; idle_inputs(); spur_dok = 0;
    inst_sram_addr = '0; data_sram_addr = '0; data_sram_wdata = '0;
    addr_wait = 0; data_wait = 0; cur_inst = '0; cur_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req, wr, size, addr, wstrb, wdata, stallreq} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req %b wr %b size %0d addr %h exp all 0", req, wr, size, addr);
    end
    checks++;
    if (fsm_state !== ST_IDLE || inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got %0d/%h/%h exp 0/0/0", fsm_state, inst_sram_rdata, data_sram_rdata);
    end
    @(posedge clk); #2 rstn = 1;
  endtask

  task automatic test_load();
    run_access("load", 0, 32'h0, 1, 4'b0000, 32'h0000_1000, 32'h0, SIZE_WORD, 3);
  endtask

  task automatic test_store_fetch();
    run_access("store_fetch", 1, 32'hBFC0_0000, 1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, SIZE_BYTE, 5);
  endtask

  task automatic test_backpressure();
    addr_wait = 3; data_wait = 2;
    run_access("backpressure", 0, 32'h0, 1, 4'b0000, 32'h0000_3000, 32'h0, SIZE_WORD, 8);
    addr_wait = 0; data_wait = 0;
  endtask

  task automatic test_size_decode();
    logic [3:0] wens [6] = '{4'b1100, 4'b0011, 4'b0001, 4'b1000, 4'b1111, 4'b0110};
    logic [1:0] sizes[6] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
    for (int i = 0; i < 6; i++) begin
      run_access("size_decode", 0, 32'h0, 1, wens[i], $urandom & 32'hFFFF_FFFC, $urandom, sizes[i], 3);
    end
    run_access("fetch_only", 1, 32'h0000_0040, 0, 4'b0000, 32'h0, 32'h0, SIZE_WORD, 3);
  endtask

  task automatic test_spurious();
    // spurious data_ok while idle
    @(posedge clk); #2 spur_dok = 1;
    @(posedge clk); #2 spur_dok = 0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_IDLE || data_sram_rdata !== cur_data || inst_sram_rdata !== cur_inst) begin
      failures++;
      $display("FAIL spur_idle got %0d/%h/%h exp 0/%h/%h", fsm_state, data_sram_rdata, inst_sram_rdata, cur_data, cur_inst);
    end
    // spurious data_ok while the data request waits for addr_ok
    addr_wait = 2;
    exp_q.push_back({1'b0, 2'd2, 4'b0000, 32'h0000_4000, 32'h0});
    @(posedge clk); #2;
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_4000; data_sram_wdata = '0;
    @(posedge clk); #2 spur_dok = 1;
    @(posedge clk); #2 spur_dok = 0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_DREQ || data_sram_rdata !== cur_data) begin
      failures++;
      $display("FAIL spur_dreq got %0d/%h exp %0d/%h", fsm_state, data_sram_rdata, ST_DREQ, cur_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fsm_state !== ST_DONE || data_sram_rdata !== resp_of(32'h0000_4000)) begin
      failures++;
      $display("FAIL spur_done got %0d/%h exp %0d/%h", fsm_state, data_sram_rdata, ST_DONE, resp_of(32'h0000_4000));
    end
    cur_data = resp_of(32'h0000_4000);
    @(posedge clk); #2 idle_inputs();
    addr_wait = 0;
  endtask

  task automatic test_reset_iwait();
    data_wait = 3;
    exp_q.push_back({1'b0, 2'd2, 4'b0000, 32'h0000_5000, 32'h0});
    @(posedge clk); #2;
    inst_sram_en = 1; inst_sram_addr = 32'h0000_5000;
    repeat (4) @(negedge clk);
    checks++;
    if (fsm_state !== ST_IWAIT) begin
      failures++;
      $display("FAIL iwait_reach got %0d exp %0d", fsm_state, ST_IWAIT);
    end
    #1 rstn = 0;
    #1;
    checks++;
    if (fsm_state !== ST_IDLE || req !== 1'b0 || stallreq !== 1'b0) begin
      failures++;
      $display("FAIL reset_iwait got state %0d req %b stall %b exp 0 0 0", fsm_state, req, stallreq);
    end
    checks++;
    if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bufs got %h/%h exp 0/0", inst_sram_rdata, data_sram_rdata);
    end
    cur_inst = '0; cur_data = '0;
    idle_inputs(); data_wait = 0;
    @(posedge clk); @(posedge clk); #2 rstn = 1;
    run_access("after_reset", 1, 32'hBFC0_0000, 0, 4'b0000, 32'h0, 32'h0, SIZE_WORD, 3);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_load();
    test_store_fetch();
    test_backpressure();
    test_size_decode();
    test_spurious();
    test_reset_iwait();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_txn got %0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
